// File: rtl/seq_muldiv_if.sv
// Handshake and operand/result bundle for seq_muldiv_unit.
// Optional port sgn exists only when MDU_SIGNED_EN is defined.
interface seq_muldiv_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef MDU_SIGNED_EN
   logic             sgn;
`endif
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [1:0]       flags;
   logic             dbz;

`ifdef MDU_SIGNED_EN
   modport master (output start, op, a, b, sgn,
                   input  ready, busy, done, result, flags, dbz);
   modport slave  (input  start, op, a, b, sgn,
                   output ready, busy, done, result, flags, dbz);
`else
   modport master (output start, op, a, b,
                   input  ready, busy, done, result, flags, dbz);
   modport slave  (input  start, op, a, b,
                   output ready, busy, done, result, flags, dbz);
`endif
endinterface

// File: rtl/seq_muldiv_unit.sv
// Iterative multiply/divide unit: MULL, MULH, DIV, REM, one bit per cycle.
// Shift-add multiply and restoring divide share one WIDTH+WIDTH accumulator.
// Optional signed support is enabled by defining MDU_SIGNED_EN.
module seq_muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input logic          clk,
   input logic          rst_n,
   seq_muldiv_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e             state;
   logic [CNT_W-1:0]   cnt;
   logic [1:0]         op_r;
   logic [WIDTH-1:0]   opnd_b;
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic               neg_q;
   logic               neg_r;
   logic               dbz_pend;

   logic               sa_c;
   logic               sb_c;
   logic [WIDTH-1:0]   mag_a_c;
   logic [WIDTH-1:0]   mag_b_c;
   logic               div_zero_c;

   logic [WIDTH:0]     mul_sum_c;
   logic [WIDTH-1:0]   mul_hi_c;
   logic [WIDTH-1:0]   mul_lo_c;
   logic [WIDTH:0]     div_sh_c;
   logic [WIDTH:0]     div_diff_c;
   logic [WIDTH-1:0]   div_hi_c;
   logic [WIDTH-1:0]   div_lo_c;

   logic [2*WIDTH-1:0] prod_c;
   logic [2*WIDTH-1:0] prod_fix_c;
   logic [WIDTH-1:0]   quo_fix_c;
   logic [WIDTH-1:0]   rem_fix_c;
   logic [WIDTH-1:0]   res_c;

   // Operand signs and magnitudes taken at acceptance
`ifdef MDU_SIGNED_EN
   always_comb begin
      sa_c    = bus.sgn & bus.a[WIDTH-1];
      sb_c    = bus.sgn & bus.b[WIDTH-1];
      mag_a_c = sa_c ? (-bus.a) : bus.a;
      mag_b_c = sb_c ? (-bus.b) : bus.b;
   end
`else
   always_comb begin
      sa_c    = 1'b0;
      sb_c    = 1'b0;
      mag_a_c = bus.a;
      mag_b_c = bus.b;
   end
`endif

   assign div_zero_c = bus.op[1] & (bus.b == '0);

   // One shift-add / restoring-divide step on the accumulator
   always_comb begin
      mul_sum_c  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : (WIDTH+1)'(0));
      mul_hi_c   = mul_sum_c[WIDTH:1];
      mul_lo_c   = {mul_sum_c[0], acc_lo[WIDTH-1:1]};
      div_sh_c   = {acc_hi, acc_lo[WIDTH-1]};
      div_diff_c = div_sh_c - {1'b0, opnd_b};
      div_hi_c   = div_diff_c[WIDTH] ? div_sh_c[WIDTH-1:0] : div_diff_c[WIDTH-1:0];
      div_lo_c   = {acc_lo[WIDTH-2:0], ~div_diff_c[WIDTH]};
   end

   // Sign correction and final result select, applied on the DONE entry edge
   always_comb begin
      prod_c     = {acc_hi, acc_lo};
      prod_fix_c = neg_q ? (-prod_c) : prod_c;
      quo_fix_c  = neg_q ? (-acc_lo) : acc_lo;
      rem_fix_c  = neg_r ? (-acc_hi) : acc_hi;
      case (op_r)
         2'b00:   res_c = prod_fix_c[WIDTH-1:0];
         2'b01:   res_c = prod_fix_c[2*WIDTH-1:WIDTH];
         2'b10:   res_c = quo_fix_c;
         default: res_c = rem_fix_c;
      endcase
   end

   // Control FSM, datapath registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         op_r       <= '0;
         opnd_b     <= '0;
         acc_hi     <= '0;
         acc_lo     <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         dbz_pend   <= 1'b0;
         bus.ready  <= 1'b1;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.result <= '0;
         bus.flags  <= 2'b10;
         bus.dbz    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state     <= S_RUN;
                  op_r      <= bus.op;
                  bus.ready <= 1'b0;
                  bus.busy  <= 1'b1;
                  if (div_zero_c) begin
                     // Zero-length run: result preloaded, no sign correction
                     cnt      <= '0;
                     acc_hi   <= bus.a;
                     acc_lo   <= '1;
                     opnd_b   <= bus.b;
                     neg_q    <= 1'b0;
                     neg_r    <= 1'b0;
                     dbz_pend <= 1'b1;
                  end else begin
                     cnt      <= CNT_W'(WIDTH);
                     acc_hi   <= '0;
                     acc_lo   <= bus.op[1] ? mag_a_c : mag_b_c;
                     opnd_b   <= bus.op[1] ? mag_b_c : mag_a_c;
                     neg_q    <= sa_c ^ sb_c;
                     neg_r    <= sa_c;
                     dbz_pend <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
                  if (op_r[1]) begin
                     acc_hi <= div_hi_c;
                     acc_lo <= div_lo_c;
                  end else begin
                     acc_hi <= mul_hi_c;
                     acc_lo <= mul_lo_c;
                  end
               end else begin
                  state      <= S_DONE;
                  bus.done   <= 1'b1;
                  bus.result <= res_c;
                  bus.flags  <= {(res_c == '0), res_c[WIDTH-1]};
                  bus.dbz    <= dbz_pend;
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               bus.done  <= 1'b0;
               bus.busy  <= 1'b0;
               bus.ready <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
